// File: rtl/dot4_accum.sv
// Streaming signed dot-product engine: registered 4-bit operand pairs feed a
// Baugh-Wooley multiplier, and products are accumulated into LEN-pair sums.

module mult4x4 (
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic [7:0] Product
);

  logic pp;

  // Baugh-Wooley: sign-row/column partial products inverted, 2^4 + 2^7 correction.
  always_comb begin
    Product = 8'h90;
    pp      = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned j = 0; j < 4; j++) begin
        pp = A[j] & B[i];
        if ((i == 3) != (j == 3)) pp = ~pp;
        Product = Product + (8'({7'b0, pp}) << (i + j));
      end
    end
  end

endmodule

module dot4_accum #(
  parameter int LEN   = 4,
  parameter int ACC_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       InA,
  input  logic [3:0]       InB,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] DotOut
);

  localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

  logic [3:0]       opA_q, opB_q;
  logic             s1_valid;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [7:0]       product;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] sum;
  logic             s1_last, stall, accept, advance, complete;

  mult4x4 u_mult (
    .A       (opA_q),
    .B       (opB_q),
    .Product (product)
  );

  assign prod_ext = ACC_W'($signed(product));
  assign sum      = acc + prod_ext;
  assign s1_last  = (cnt == LAST);
  assign stall    = s1_valid && s1_last && out_valid && !out_ready;
  assign in_ready = !stall && !clear;
  assign accept   = in_valid && in_ready;
  assign advance  = s1_valid && !stall && !clear;
  assign complete = advance && s1_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opA_q    <= '0;
      opB_q    <= '0;
      s1_valid <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
    end else begin
      if (accept) begin
        opA_q    <= InA;
        opB_q    <= InB;
        s1_valid <= 1'b1;
      end else if (advance) begin
        s1_valid <= 1'b0;
      end
      if (advance) begin
        if (s1_last) begin
          acc <= '0;
          cnt <= '0;
        end else begin
          acc <= sum;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // A completion load wins over a same-edge handshake, keeping out_valid set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      DotOut    <= '0;
    end else if (complete) begin
      out_valid <= 1'b1;
      DotOut    <= sum;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dot4_accum.sv
// Scoreboard bench for dot4_accum: LEN=4/ACC_W=12 directed scenarios and an
// exhaustive LEN=1/ACC_W=8 product sweep with random output stalls.

module tb_dot4_accum;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        clear4, in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0]  ina4, inb4;
  logic [11:0] dotout4;

  logic        clear1, in_valid1, in_ready1, out_valid1, out_ready1;
  logic [3:0]  ina1, inb1;
  logic [7:0]  dotout1;

  dot4_accum #(.LEN(4), .ACC_W(12)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .clear(clear4), .in_valid(in_valid4),
    .in_ready(in_ready4), .InA(ina4), .InB(inb4), .out_valid(out_valid4),
    .out_ready(out_ready4), .DotOut(dotout4)
  );

  dot4_accum #(.LEN(1), .ACC_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1),
    .in_ready(in_ready1), .InA(ina1), .InB(inb1), .out_valid(out_valid1),
    .out_ready(out_ready1), .DotOut(dotout1)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wait_cycles4 = 0;
  int model_acc = 0;
  int model_cnt = 0;
  int seen1 = 0;
  bit rnd_en = 1'b0;

  logic [11:0] q4[$];
  logic [7:0]  q1[$];
  int          hs4[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    model_acc = 0;
    model_cnt = 0;
  endtask

  task automatic send4(input int a, input int b);
    int n = 0;
    in_valid4 = 1'b1;
    ina4 = 4'(a);
    inb4 = 4'(b);
    @(negedge clk);
    while (!in_ready4 && n < 200) begin
      n++;
      @(negedge clk);
    end
    wait_cycles4 += n;
    if (n >= 200) check("send4_timeout", 0, 1);
    model_acc += a * b;
    model_cnt++;
    if (model_cnt == 4) begin
      q4.push_back(12'(model_acc));
      model_reset();
    end
    @(posedge clk);
    #1;
    in_valid4 = 1'b0;
  endtask

  task automatic send1(input int a, input int b);
    int n = 0;
    in_valid1 = 1'b1;
    ina1 = 4'(a);
    inb1 = 4'(b);
    @(negedge clk);
    while (!in_ready1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (n >= 200) check("send1_timeout", 0, 1);
    q1.push_back(8'(a * b));
    @(posedge clk);
    #1;
    in_valid1 = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n && out_valid4 && out_ready4) begin
      hs4.push_back(cyc);
      if (q4.size() == 0) check("dut4_extra_result", 1, 0);
      else check("dut4_result", dotout4, q4.pop_front());
    end
    if (rst_n && out_valid1 && out_ready1) begin
      seen1++;
      if (q1.size() == 0) check("dut1_extra_result", 1, 0);
      else check("dut1_product", dotout1, q1.pop_front());
    end
  end

  initial begin
    forever begin
      out_ready1 = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      #1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    clear4 = 1'b0; in_valid4 = 1'b0; ina4 = '0; inb4 = '0; out_ready4 = 1'b1;
    clear1 = 1'b0; in_valid1 = 1'b0; ina1 = '0; inb1 = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid4", out_valid4, 0);
    check("rst_dotout4", dotout4, 0);
    check("rst_out_valid1", out_valid1, 0);
    check("rst_dotout1", dotout1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready4", in_ready4, 1);
    check("rst_in_ready1", in_ready1, 1);
    repeat (2) @(posedge clk);
    #1;

    // Single vector and its latency
    send4(1, 2); send4(3, -1); send4(-8, -8); send4(7, -8);
    check("s1_not_yet_valid", out_valid4, 0);
    @(posedge clk); #1;
    check("s1_valid", out_valid4, 1);
    check("s1_dotout", dotout4, 12'h007);
    @(posedge clk); #1;
    check("s1_valid_one_cycle", out_valid4, 0);

    // Back-to-back vectors
    hs4.delete();
    wait_cycles4 = 0;
    repeat (4) send4(-8, -8);
    repeat (4) send4(-8, 7);
    repeat (3) @(posedge clk);
    #1;
    check("b2b_no_stall", wait_cycles4, 0);
    check("b2b_results", hs4.size(), 2);
    if (hs4.size() == 2) check("b2b_spacing", hs4[1] - hs4[0], 4);

    // Backpressure
    out_ready4 = 1'b0;
    wait_cycles4 = 0;
    repeat (4) send4(-8, -8);
    repeat (4) send4(-8, 7);
    check("bp_no_wait", wait_cycles4, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready4, 0);
      check("bp_valid_held", out_valid4, 1);
      check("bp_dotout_held", dotout4, 12'h100);
    end
    out_ready4 = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", out_valid4, 1);
    check("bp_release_dotout", dotout4, 12'hF20);
    @(posedge clk); #1;
    check("bp_drained", out_valid4, 0);

    // clear mid-vector with a pending result
    out_ready4 = 1'b0;
    repeat (4) send4(1, 1);
    @(posedge clk); #1;
    check("clr_pending_valid", out_valid4, 1);
    send4(7, 7); send4(7, 7);
    model_reset();
    clear4 = 1'b1; in_valid4 = 1'b1; ina4 = 4'd5; inb4 = 4'd5;
    @(negedge clk);
    check("clr_in_ready_low", in_ready4, 0);
    @(posedge clk); #1;
    clear4 = 1'b0; in_valid4 = 1'b0;
    check("clr_out_valid_kept", out_valid4, 1);
    check("clr_dotout_kept", dotout4, 12'h004);
    out_ready4 = 1'b1;
    send4(1, 1); send4(2, 2); send4(-1, 3); send4(0, 5);
    repeat (3) @(posedge clk);
    #1;
    check("clr_drained", q4.size(), 0);

    // LEN=1 exhaustive sweep with random stalls
    rnd_en = 1'b1;
    for (int a = -8; a < 8; a++)
      for (int b = -8; b < 8; b++)
        send1(a, b);
    rnd_en = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("sweep_queue_empty", q1.size(), 0);
    check("sweep_count", seen1, 256);

    // Asynchronous reset mid-vector with a pending result
    out_ready4 = 1'b0;
    repeat (4) send4(2, 2);
    @(posedge clk); #1;
    check("ar_pending_valid", out_valid4, 1);
    send4(1, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", out_valid4, 0);
    check("ar_dotout", dotout4, 0);
    q4.delete();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ar_in_ready", in_ready4, 1);
    out_ready4 = 1'b1;
    repeat (4) send4(1, 2);
    repeat (3) @(posedge clk);
    #1;
    check("ar_fresh_vector_done", q4.size(), 0);
    check("ar_dotout_fresh", dotout4, 12'h008);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
